// File: rtl/axil_csr_pkg.sv
// Shared register map, response codes and byte-strobe helper for the
// multi-channel AXI4-Lite CSR bank.
package axil_csr_pkg;

  localparam int unsigned ID_OFF       = 'h00;
  localparam int unsigned IRQ_EN_OFF   = 'h04;
  localparam int unsigned IRQ_STAT_OFF = 'h08;
  localparam int unsigned CH_BASE      = 'h20;
  localparam int unsigned CH_STRIDE    = 'h10;

  localparam int unsigned CTRL_OFF   = 'h0;
  localparam int unsigned LEN_OFF    = 'h4;
  localparam int unsigned STATUS_OFF = 'h8;
  localparam int unsigned BYTES_OFF  = 'hC;

  localparam int CTRL_START    = 0;
  localparam int CTRL_SOFT_RST = 1;
  localparam int CTRL_CLR_DONE = 2;
  localparam int CTRL_CLR_ERR  = 3;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic logic [31:0] apply_wstrb32(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
    logic [31:0] merged;
    merged = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) merged[8*b +: 8] = new_val[8*b +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/axil_csr_chan.sv
// Per-channel state: LEN register, sticky done/error flags and the
// one-cycle start / soft-reset strobes driven by CTRL writes.
module axil_csr_chan
  import axil_csr_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_wr_ctrl,
  input  logic        i_wr_len,
  input  logic [31:0] i_wdata,
  input  logic [3:0]  i_wstrb,
  input  logic        i_done_pulse,
  input  logic        i_error_pulse,
  output logic        o_start_pulse,
  output logic        o_soft_reset_pulse,
  output logic [31:0] o_len,
  output logic        o_done_sticky,
  output logic        o_err_sticky
);

  logic        r_start;
  logic        r_soft_reset;
  logic [31:0] r_len;
  logic        r_done_sticky;
  logic        r_err_sticky;
  logic        w_clr_done;
  logic        w_clr_err;

  // Soft reset wipes both sticky flags in addition to the explicit clears.
  assign w_clr_done = i_wr_ctrl && (i_wdata[CTRL_CLR_DONE] || i_wdata[CTRL_SOFT_RST]);
  assign w_clr_err  = i_wr_ctrl && (i_wdata[CTRL_CLR_ERR]  || i_wdata[CTRL_SOFT_RST]);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_start       <= 1'b0;
      r_soft_reset  <= 1'b0;
      r_len         <= '0;
      r_done_sticky <= 1'b0;
      r_err_sticky  <= 1'b0;
    end else begin
      r_start      <= i_wr_ctrl && i_wdata[CTRL_START];
      r_soft_reset <= i_wr_ctrl && i_wdata[CTRL_SOFT_RST];
      if (i_wr_len) r_len <= apply_wstrb32(r_len, i_wdata, i_wstrb);
      // A completion event in the clearing cycle must not be lost.
      r_done_sticky <= i_done_pulse  || (r_done_sticky && !w_clr_done);
      r_err_sticky  <= i_error_pulse || (r_err_sticky  && !w_clr_err);
    end
  end

  assign o_start_pulse      = r_start;
  assign o_soft_reset_pulse = r_soft_reset;
  assign o_len              = r_len;
  assign o_done_sticky      = r_done_sticky;
  assign o_err_sticky       = r_err_sticky;

endmodule

// File: rtl/axil_csr_bank.sv
// AXI4-Lite slave front end for NUM_CH packet-mover channels: independent
// AW/W holds, single outstanding read, address decode and the level IRQ.
module axil_csr_bank
  import axil_csr_pkg::*;
#(
  parameter int          NUM_CH   = 2,
  parameter int          ADDR_W   = 8,
  parameter logic [31:0] ID_VALUE = 32'hA0B1_0002
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_W-1:0]     s_axi_awaddr,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [31:0]           s_axi_wdata,
  input  logic [3:0]            s_axi_wstrb,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [ADDR_W-1:0]     s_axi_araddr,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [31:0]           s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  output logic [NUM_CH-1:0]     start_pulse,
  output logic [NUM_CH-1:0]     soft_reset_pulse,
  output logic [32*NUM_CH-1:0]  len_bytes,
  input  logic [NUM_CH-1:0]     busy,
  input  logic [NUM_CH-1:0]     done_pulse,
  input  logic [NUM_CH-1:0]     error_pulse,
  input  logic [32*NUM_CH-1:0]  bytes_moved,
  output logic                  irq
);

  logic                r_aw_hold;
  logic [ADDR_W-1:0]   r_aw_addr;
  logic                r_w_hold;
  logic [31:0]         r_w_data;
  logic [3:0]          r_w_strb;
  logic                r_bvalid;
  logic [1:0]          r_bresp;
  logic                r_rvalid;
  logic [31:0]         r_rdata;
  logic [1:0]          r_rresp;
  logic [2*NUM_CH-1:0] r_irq_en;
  logic                r_irq;

  logic                w_commit;
  logic                w_ar_hs;
  logic                w_irq_en_sel;
  logic                w_wr_ok;
  logic [NUM_CH-1:0]   w_ctrl_sel;
  logic [NUM_CH-1:0]   w_len_sel;
  logic [NUM_CH-1:0]   w_rd_hit;
  logic [NUM_CH-1:0]   w_done_sticky;
  logic [NUM_CH-1:0]   w_err_sticky;
  logic [2*NUM_CH-1:0] w_irq_stat;
  logic [2*NUM_CH-1:0] w_irq_en_merged;
  logic [31:0]         w_len [NUM_CH];
  logic [31:0]         w_rd_data;
  logic                w_rd_ok;

  assign s_axi_awready = !rst && !r_aw_hold && !r_bvalid;
  assign s_axi_wready  = !rst && !r_w_hold && !r_bvalid;
  assign s_axi_arready = !rst && !r_rvalid;

  assign w_commit     = r_aw_hold && r_w_hold && !r_bvalid;
  assign w_ar_hs      = s_axi_arvalid && s_axi_arready;
  assign w_irq_en_sel = (r_aw_addr == ADDR_W'(IRQ_EN_OFF));
  assign w_wr_ok      = w_irq_en_sel || (|w_ctrl_sel) || (|w_len_sel);

  for (genvar gi = 0; gi < 2*NUM_CH; gi++) begin : g_en
    assign w_irq_en_merged[gi] = r_w_strb[gi/8] ? r_w_data[gi] : r_irq_en[gi];
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    localparam logic [ADDR_W-1:0] CH_ADDR = ADDR_W'(CH_BASE + CH_STRIDE*gi);
    logic w_wr_hit;

    // Full-width compare of the upper bits so aliases above the map miss.
    assign w_wr_hit       = (r_aw_addr[ADDR_W-1:4] == CH_ADDR[ADDR_W-1:4]);
    assign w_rd_hit[gi]   = (s_axi_araddr[ADDR_W-1:4] == CH_ADDR[ADDR_W-1:4]);
    assign w_ctrl_sel[gi] = w_wr_hit && (r_aw_addr[3:0] == 4'(CTRL_OFF));
    assign w_len_sel[gi]  = w_wr_hit && (r_aw_addr[3:0] == 4'(LEN_OFF));

    assign w_irq_stat[2*gi]   = w_done_sticky[gi] && r_irq_en[2*gi];
    assign w_irq_stat[2*gi+1] = w_err_sticky[gi]  && r_irq_en[2*gi+1];

    axil_csr_chan u_chan (
      .clk                (clk),
      .rst                (rst),
      .i_wr_ctrl          (w_commit && w_ctrl_sel[gi]),
      .i_wr_len           (w_commit && w_len_sel[gi]),
      .i_wdata            (r_w_data),
      .i_wstrb            (r_w_strb),
      .i_done_pulse       (done_pulse[gi]),
      .i_error_pulse      (error_pulse[gi]),
      .o_start_pulse      (start_pulse[gi]),
      .o_soft_reset_pulse (soft_reset_pulse[gi]),
      .o_len              (w_len[gi]),
      .o_done_sticky      (w_done_sticky[gi]),
      .o_err_sticky       (w_err_sticky[gi])
    );

    assign len_bytes[32*gi +: 32] = w_len[gi];
  end

  always_comb begin
    w_rd_data = '0;
    w_rd_ok   = 1'b0;
    if (s_axi_araddr == ADDR_W'(ID_OFF)) begin
      w_rd_data = ID_VALUE;
      w_rd_ok   = 1'b1;
    end else if (s_axi_araddr == ADDR_W'(IRQ_EN_OFF)) begin
      w_rd_data = 32'(r_irq_en);
      w_rd_ok   = 1'b1;
    end else if (s_axi_araddr == ADDR_W'(IRQ_STAT_OFF)) begin
      w_rd_data = 32'(w_irq_stat);
      w_rd_ok   = 1'b1;
    end
    for (int c = 0; c < NUM_CH; c++) begin
      if (w_rd_hit[c]) begin
        case (s_axi_araddr[3:0])
          4'(CTRL_OFF): begin
            w_rd_ok = 1'b1;
          end
          4'(LEN_OFF): begin
            w_rd_data = w_len[c];
            w_rd_ok   = 1'b1;
          end
          4'(STATUS_OFF): begin
            w_rd_data = {29'b0, busy[c], w_err_sticky[c], w_done_sticky[c]};
            w_rd_ok   = 1'b1;
          end
          4'(BYTES_OFF): begin
            w_rd_data = bytes_moved[32*c +: 32];
            w_rd_ok   = 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_aw_hold <= 1'b0;
      r_aw_addr <= '0;
      r_w_hold  <= 1'b0;
      r_w_data  <= '0;
      r_w_strb  <= '0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_rresp   <= RESP_OKAY;
      r_irq_en  <= '0;
      r_irq     <= 1'b0;
    end else begin
      if (s_axi_awvalid && s_axi_awready) begin
        r_aw_hold <= 1'b1;
        r_aw_addr <= s_axi_awaddr;
      end
      if (s_axi_wvalid && s_axi_wready) begin
        r_w_hold <= 1'b1;
        r_w_data <= s_axi_wdata;
        r_w_strb <= s_axi_wstrb;
      end
      if (w_commit) begin
        r_aw_hold <= 1'b0;
        r_w_hold  <= 1'b0;
        r_bvalid  <= 1'b1;
        r_bresp   <= w_wr_ok ? RESP_OKAY : RESP_SLVERR;
        if (w_irq_en_sel) r_irq_en <= w_irq_en_merged;
      end else if (r_bvalid && s_axi_bready) begin
        r_bvalid <= 1'b0;
      end

      if (w_ar_hs) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rd_data;
        r_rresp  <= w_rd_ok ? RESP_OKAY : RESP_SLVERR;
      end else if (r_rvalid && s_axi_rready) begin
        r_rvalid <= 1'b0;
      end

      r_irq <= |w_irq_stat;
    end
  end

  assign s_axi_bvalid = r_bvalid;
  assign s_axi_bresp  = r_bresp;
  assign s_axi_rvalid = r_rvalid;
  assign s_axi_rdata  = r_rdata;
  assign s_axi_rresp  = r_rresp;
  assign irq          = r_irq;

endmodule

// File: tb/tb_axil_csr_bank.sv
// Randomised scoreboard bench for axil_csr_bank against an array-based
// register model; a negedge monitor checks every B and R beat.
module tb_axil_csr_bank;

  localparam int          NUM_CH   = 2;
  localparam int          ADDR_W   = 8;
  localparam logic [31:0] ID_VALUE = 32'hA0B1_0002;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [ADDR_W-1:0]    s_axi_awaddr = '0;
  logic                 s_axi_awvalid = 1'b0;
  logic                 s_axi_awready;
  logic [31:0]          s_axi_wdata = '0;
  logic [3:0]           s_axi_wstrb = '0;
  logic                 s_axi_wvalid = 1'b0;
  logic                 s_axi_wready;
  logic [1:0]           s_axi_bresp;
  logic                 s_axi_bvalid;
  logic                 s_axi_bready = 1'b1;
  logic [ADDR_W-1:0]    s_axi_araddr = '0;
  logic                 s_axi_arvalid = 1'b0;
  logic                 s_axi_arready;
  logic [31:0]          s_axi_rdata;
  logic [1:0]           s_axi_rresp;
  logic                 s_axi_rvalid;
  logic                 s_axi_rready = 1'b1;
  logic [NUM_CH-1:0]    start_pulse;
  logic [NUM_CH-1:0]    soft_reset_pulse;
  logic [32*NUM_CH-1:0] len_bytes;
  logic [NUM_CH-1:0]    busy = '0;
  logic [NUM_CH-1:0]    done_pulse = '0;
  logic [NUM_CH-1:0]    error_pulse = '0;
  logic [32*NUM_CH-1:0] bytes_moved = '0;
  logic                 irq;

  axil_csr_bank #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .ID_VALUE(ID_VALUE)) dut (
    .clk(clk), .rst(rst),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid),
    .s_axi_rready(s_axi_rready),
    .start_pulse(start_pulse), .soft_reset_pulse(soft_reset_pulse), .len_bytes(len_bytes),
    .busy(busy), .done_pulse(done_pulse), .error_pulse(error_pulse),
    .bytes_moved(bytes_moved), .irq(irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural register model.
  logic [31:0]       len_m [NUM_CH];
  logic [31:0]       en_m;
  logic [NUM_CH-1:0] done_m;
  logic [NUM_CH-1:0] err_m;
  logic              irq_at_b;

  logic [1:0]  exp_b [$];
  logic [33:0] exp_r [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int c = 0; c < NUM_CH; c++) len_m[c] = '0;
    en_m   = '0;
    done_m = '0;
    err_m  = '0;
  endfunction

  function automatic logic [31:0] model_stat();
    logic [31:0] s;
    s = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      s[2*c]   = done_m[c] & en_m[2*c];
      s[2*c+1] = err_m[c]  & en_m[2*c+1];
    end
    return s;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] m;
    m = o;
    for (int b = 0; b < 4; b++) if (s[b]) m[8*b +: 8] = d[8*b +: 8];
    return m;
  endfunction

  function automatic void model_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] r);
    int c;
    int off;
    d = '0;
    r = 2'b10;
    if (a == 8'h00) begin
      d = ID_VALUE; r = 2'b00;
    end else if (a == 8'h04) begin
      d = en_m; r = 2'b00;
    end else if (a == 8'h08) begin
      d = model_stat(); r = 2'b00;
    end else if (int'(a) >= 32 && int'(a) < 32 + 16*NUM_CH && a[1:0] == 2'b00) begin
      c   = (int'(a) - 32) / 16;
      off = int'(a) % 16;
      r   = 2'b00;
      case (off)
        4:       d = len_m[c];
        8:       d = {29'b0, busy[c], err_m[c], done_m[c]};
        12:      d = bytes_moved[32*c +: 32];
        default: d = '0;
      endcase
    end
  endfunction

  function automatic void model_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                                      input logic [NUM_CH-1:0] ev_done, output logic [1:0] r,
                                      output logic [NUM_CH-1:0] st, output logic [NUM_CH-1:0] sr);
    int c;
    int off;
    r  = 2'b10;
    st = '0;
    sr = '0;
    if (a == 8'h04) begin
      en_m = merge(en_m, d, s) & ((32'd1 << (2*NUM_CH)) - 32'd1);
      r    = 2'b00;
    end else if (int'(a) >= 32 && int'(a) < 32 + 16*NUM_CH) begin
      c   = (int'(a) - 32) / 16;
      off = int'(a) % 16;
      if (off == 0) begin
        r     = 2'b00;
        st[c] = d[0];
        sr[c] = d[1];
        if (d[1] || d[2]) done_m[c] = 1'b0;
        if (d[1] || d[3]) err_m[c]  = 1'b0;
      end else if (off == 4) begin
        r        = 2'b00;
        len_m[c] = merge(len_m[c], d, s);
      end
    end
    done_m = done_m | ev_done;
  endfunction

  task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_lag, input logic [NUM_CH-1:0] ev_done, input bit wait_b);
    logic [1:0]        er;
    logic [NUM_CH-1:0] est;
    logic [NUM_CH-1:0] esr;
    bit aw_done = 0, w_done = 0, aw_hs, w_hs;
    int k = 0;
    model_write(a, d, s, ev_done, er, est, esr);
    exp_b.push_back(er);
    $display("WR addr=0x%02h data=0x%08h strb=0x%h lag=%0d bresp_exp=%0b", a, d, s, aw_lag, er);
    s_axi_awaddr = a; s_axi_wdata = d; s_axi_wstrb = s;
    while (!(aw_done && w_done)) begin
      if (!aw_done) s_axi_awvalid = (k >= ((aw_lag > 0) ? aw_lag : 0));
      if (!w_done)  s_axi_wvalid  = (k >= ((aw_lag < 0) ? -aw_lag : 0));
      aw_hs = s_axi_awvalid && s_axi_awready;
      w_hs  = s_axi_wvalid && s_axi_wready;
      @(posedge clk); #1;
      if (aw_hs) begin aw_done = 1; s_axi_awvalid = 1'b0; end
      if (w_hs)  begin w_done = 1;  s_axi_wvalid  = 1'b0; end
      k++;
      if (k > 40) begin
        check("aw_w_accept_timeout", 32'd0, 32'd1);
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        return;
      end
    end
    done_pulse = ev_done;  // commit cycle
    @(posedge clk); #1;
    done_pulse = '0;
    check("bvalid_rise", 32'(s_axi_bvalid), 32'd1);
    irq_at_b = irq;
    if (wait_b) begin
      check("start_pulse", 32'(start_pulse), 32'(est));
      check("soft_reset_pulse", 32'(soft_reset_pulse), 32'(esr));
      k = 0;
      while (s_axi_bvalid && k < 20) begin @(posedge clk); #1; k++; end
      check("bvalid_drop", 32'(s_axi_bvalid), 32'd0);
      check("pulses_one_cycle", 32'({start_pulse, soft_reset_pulse}), 32'd0);
    end
  endtask

  task automatic axi_read(input logic [7:0] a);
    logic [31:0] d;
    logic [1:0]  r;
    bit hs;
    int k = 0;
    model_read(a, d, r);
    exp_r.push_back({r, d});
    $display("RD addr=0x%02h rdata_exp=0x%08h rresp_exp=%0b", a, d, r);
    s_axi_araddr = a; s_axi_arvalid = 1'b1;
    do begin
      hs = s_axi_arvalid && s_axi_arready;
      @(posedge clk); #1;
      k++;
    end while (!hs && k < 20);
    s_axi_arvalid = 1'b0;
    if (!hs) check("ar_accept_timeout", 32'd0, 32'd1);
    k = 0;
    while (s_axi_rvalid && k < 20) begin @(posedge clk); #1; k++; end
    check("rvalid_drop", 32'(s_axi_rvalid), 32'd0);
  endtask

  task automatic events(input logic [NUM_CH-1:0] dn, input logic [NUM_CH-1:0] er);
    done_pulse = dn; error_pulse = er;
    @(posedge clk); #1;
    done_pulse = '0; error_pulse = '0;
    done_m = done_m | dn;
    err_m  = err_m | er;
    $display("EV done=%b err=%b", dn, er);
  endtask

  task automatic check_irq(input string name);
    @(posedge clk); #1;
    check(name, 32'(irq), 32'(|model_stat()));
  endtask

  task automatic check_len();
    for (int c = 0; c < NUM_CH; c++) check("len_bytes", len_bytes[32*c +: 32], len_m[c]);
  endtask

  // Scoreboard monitor: compares each beat on the edge that completes it.
  initial begin
    logic [1:0]  eb;
    logic [33:0] er;
    forever begin
      @(negedge clk);
      if (!rst && s_axi_bvalid && s_axi_bready) begin
        if (exp_b.size() == 0) check("b_unexpected", 32'd1, 32'd0);
        else begin
          eb = exp_b.pop_front();
          check("bresp", 32'(s_axi_bresp), 32'(eb));
        end
      end
      if (!rst && s_axi_rvalid && s_axi_rready) begin
        if (exp_r.size() == 0) check("r_unexpected", 32'd1, 32'd0);
        else begin
          er = exp_r.pop_front();
          check("rdata", s_axi_rdata, er[31:0]);
          check("rresp", 32'(s_axi_rresp), 32'(er[33:32]));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  logic [7:0] addr_pool [20] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h1C, 8'h20, 8'h24,
                                 8'h28, 8'h2C, 8'h30, 8'h34, 8'h38, 8'h3C, 8'h40, 8'h44,
                                 8'h22, 8'h26, 8'h35, 8'hFF};

  initial begin
    logic [7:0]  a;
    logic [31:0] d;
    model_reset();
    irq_at_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_awready", 32'(s_axi_awready), 32'd0);
    check("rst_arready", 32'(s_axi_arready), 32'd0);
    check("rst_bvalid", 32'(s_axi_bvalid), 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_readies", 32'({s_axi_awready, s_axi_wready, s_axi_arready}), 32'h7);
    check("post_rst_irq", 32'(irq), 32'd0);
    check_len();

    // LEN write with AW trailing W by three cycles, then byte-strobed merge.
    axi_write(8'h34, 32'h0000_1234, 4'hF, 3, '0, 1);
    axi_read(8'h34);
    axi_read(8'h24);
    check_len();
    axi_write(8'h34, 32'hFFFF_FFFF, 4'h2, -1, '0, 1);
    axi_read(8'h34);
    check_len();

    // Start strobe and write-only CTRL readback.
    axi_write(8'h20, 32'h1, 4'hF, -2, '0, 1);
    axi_read(8'h20);

    // Sticky done with IRQ; set wins over a simultaneous clear.
    axi_write(8'h04, 32'h1, 4'hF, 0, '0, 1);
    events(2'b01, 2'b00);
    check_irq("irq_after_done");
    axi_read(8'h28);
    axi_write(8'h20, 32'h4, 4'hF, 0, 2'b01, 1);
    axi_read(8'h28);
    check_irq("irq_set_wins");
    axi_write(8'h20, 32'h4, 4'hF, 1, '0, 1);
    check("irq_lags_clear", 32'(irq_at_b), 32'd1);
    check("irq_cleared", 32'(irq), 32'd0);
    axi_read(8'h28);
    axi_read(8'h08);

    // Error responses.
    axi_read(8'h10);
    axi_read(8'h22);
    axi_write(8'h08, 32'hFFFF_FFFF, 4'hF, 0, '0, 1);
    axi_read(8'h04);
    axi_read(8'h00);

    // Randomised traffic against the model.
    for (int i = 0; i < 60; i++) begin
      busy = NUM_CH'($urandom);
      for (int c = 0; c < NUM_CH; c++) bytes_moved[32*c +: 32] = $urandom();
      a = ($urandom_range(0, 4) == 0) ? 8'($urandom) : addr_pool[$urandom_range(0, 19)];
      d = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 15)) : $urandom();
      case ($urandom_range(0, 3))
        0, 1: begin
          axi_write(a, d, 4'($urandom), int'($urandom_range(0, 6)) - 3, '0, 1);
          check_len();
        end
        2: axi_read(a);
        default: events(NUM_CH'($urandom), NUM_CH'($urandom));
      endcase
      check_irq("irq_random");
    end

    // Stalled B channel, then reset mid-transaction.
    axi_write(8'h04, 32'h3, 4'hF, 0, '0, 1);
    events(2'b01, 2'b00);
    check_irq("irq_before_rst");
    s_axi_bready = 1'b0;
    s_axi_rready = 1'b0;
    axi_write(8'h24, 32'h0000_ABCD, 4'hF, 0, '0, 0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("stall_ready", 32'({s_axi_awready, s_axi_wready}), 32'd0);
      check("stall_bvalid", 32'(s_axi_bvalid), 32'd1);
    end
    s_axi_araddr = 8'h24; s_axi_arvalid = 1'b1;
    @(posedge clk); #1;
    s_axi_arvalid = 1'b0;
    check("stall_rvalid", 32'(s_axi_rvalid), 32'd1);
    check("stall_rdata", s_axi_rdata, len_m[0]);
    rst = 1'b1;
    @(posedge clk); #1;
    $display("RST asserted mid-transaction");
    check("rst_readies", 32'({s_axi_awready, s_axi_wready, s_axi_arready}), 32'd0);
    check("rst_valids", 32'({s_axi_bvalid, s_axi_rvalid}), 32'd0);
    check("rst_resps", 32'({s_axi_bresp, s_axi_rresp}), 32'd0);
    check("rst_rdata", s_axi_rdata, 32'd0);
    check("rst_pulses", 32'({start_pulse, soft_reset_pulse}), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    exp_b.delete();
    exp_r.delete();
    model_reset();
    check_len();
    rst = 1'b0;
    s_axi_bready = 1'b1;
    s_axi_rready = 1'b1;
    #1;
    check("rst_release_readies", 32'({s_axi_awready, s_axi_wready, s_axi_arready}), 32'h7);
    axi_read(8'h24);
    axi_read(8'h04);
    axi_read(8'h28);

    repeat (4) @(posedge clk);
    #1;
    check("b_queue_empty", 32'(exp_b.size()), 32'd0);
    check("r_queue_empty", 32'(exp_r.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
